hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard and stall controller for the 5-stage MIPS core; the producer side of operand forwarding. It detects the hazards forwarding cannot resolve (load-use, branch-in-ID operand dependence, multi-cycle data-memory access), and drives stage write-enables, bubbles and flushes. A small FSM tracks memory-wait freezes with a watchdog. A saturating counter reports stall cycles for performance debug.

## Interface
- MAX_WAIT, 64, consecutive not-ready memory cycles before timeout (≥2)
- CNT_W, 16, width of stall_count
- clk  in  1  pipeline clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID
- ID_UsesRt  in  1  instruction in ID reads rt
- ID_Branch  in  1  branch resolved in ID; needs both operands
- ID_BranchTaken, ID_Jump  in  1 each  control-flow change resolved in ID
- EX_MemRead, EX_RegWrite  in  1 each  EX-stage instruction is a load / writes a register
- EX_WriteRegister  in  5  EX-stage destination register
- MEM_MemRead  in  1  MEM-stage instruction is a load
- MEM_WriteRegister  in  5  MEM-stage destination register
- MEM_MemAccess  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- PC_Write, IFID_Write  out  1 each  PC / IF-ID register update enable
- IDEX_Write, EXMEM_Write  out  1 each  ID-EX / EX-MEM update enable
- IDEX_Bubble, MEMWB_Bubble  out  1 each  load NOP control into ID-EX / MEM-WB
- IFID_Flush  out  1  squash the fetched instruction
- mem_timeout  out  1  sticky watchdog flag
- stall_count  out  CNT_W  saturating count of cycles with PC_Write=0

## Operation
- Register 0 never creates a hazard; every match term requires the destination to be nonzero.
- load_use = EX_MemRead & (EX_WriteRegister==ID_rs | ID_UsesRt & EX_WriteRegister==ID_rt).
- br_haz = ID_Branch & ((EX_RegWrite & match(EX_WriteRegister)) | (MEM_MemRead & match(MEM_WriteRegister))). match() covers rs, and covers rt when ID_UsesRt.
- mem_wait = MEM_MemAccess & ~mem_ready.
- FSM states: RUN, MEM_WAIT, TIMEOUT. Outputs are Mealy: combinational from state and inputs.
- Priority in RUN/MEM_WAIT is mem_wait, then (load_use|br_haz), then flush.
- Freeze (mem_wait): PC_Write, IFID_Write, IDEX_Write and EXMEM_Write are 0; MEMWB_Bubble=1; IDEX_Bubble=0; IFID_Flush=0.
- Stall (load_use|br_haz): PC_Write=0, IFID_Write=0, IDEX_Bubble=1; IDEX_Write and EXMEM_Write stay 1; IFID_Flush=0.
- Flush ((ID_BranchTaken|ID_Jump) with no stall or freeze): IFID_Flush=1 and all enables are 1.
- Idle: all four enables are 1; bubbles and flush are 0.
- Transitions:
  - RUN→MEM_WAIT on mem_wait.
  - MEM_WAIT→RUN when mem_ready=1. That cycle evaluates the stall/flush rules normally.
  - MEM_WAIT→TIMEOUT when mem_wait holds and wait_cnt==MAX_WAIT-1.
  - TIMEOUT is held until reset: freeze outputs, mem_timeout=1.
- wait_cnt is cleared in any cycle without mem_wait and increments on each mem_wait cycle. Exactly MAX_WAIT consecutive not-ready cycles cause TIMEOUT on the next edge.
- stall_count increments on each cycle with PC_Write=0, including TIMEOUT. It saturates at all-ones.

## Timing
- Zero-cycle latency from inputs to control outputs; state, wait_cnt and stall_count update on the rising clk edge.
- Reset (asynchronous assert, any cycle including mid-wait): state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
  - With idle inputs during reset: PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=1 and the other outputs are 0.
- Load-use costs exactly 1 bubble. Branch after ALU op costs 1 stall cycle. Branch directly after a load costs 2 stall cycles: load_use, then br_haz via MEM_MemRead.
- A freeze coincident with a hazard suppresses IDEX_Bubble. The hazard is re-evaluated after the freeze ends.

## Structure
- Shared pipeline package holds:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, TIMEOUT=2'd2)
  - REG_ZERO=5'd0
  - MAX_WAIT default
- One sub-module, reg_match: 5-bit destination vs rs/rt comparator with nonzero qualification and ID_UsesRt gating. It is instantiated three times (EX load, EX ALU, MEM load).

## Test plan
- EX_MemRead=1, EX_WriteRegister=8, ID_rs=8 -> one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1; stall_count=1.
- Same stimulus with EX_WriteRegister=0, or ID_rt=8 with ID_UsesRt=0 -> no stall.
- Load to $9, then beq using $9 in ID -> 2 consecutive stall cycles, then IFID_Flush=1 if taken.
- MEM_MemAccess=1, mem_ready low for 3 cycles -> 3 freeze cycles with MEMWB_Bubble=1; RUN on the ready cycle; stall_count=3.
- mem_ready held low for MAX_WAIT cycles -> TIMEOUT, mem_timeout=1 and held. Assert reset_n=0 mid-state -> all outputs return to reset values immediately.
- Freeze coincident with load_use -> IDEX_Bubble=0 during freeze; exactly one bubble after mem_ready.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   state_t       - memory-wait FSM state encoding
//   REG_ZERO      - architectural zero register (never a hazard source)
//   MAX_WAIT_DEF  - default watchdog limit in consecutive not-ready cycles
// -----------------------------------------------------------------------------
package hazard_stall_unit_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO     = 5'd0;
   localparam int         MAX_WAIT_DEF = 64;

endpackage : hazard_stall_unit_pkg

// File: rtl/hazard_stall_unit_reg_match.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_reg_match
// Compares one in-flight destination register against the source operands of
// the instruction in ID.
//   i_dest     - destination register of the producing instruction
//   i_rs, i_rt - source registers of the instruction in ID
//   i_uses_rt  - ID instruction actually reads rt
//   o_match    - nonzero destination equals rs, or rt when rt is used
// -----------------------------------------------------------------------------
module hazard_stall_unit_reg_match
   import hazard_stall_unit_pkg::*;
(
   input  logic [4:0] i_dest,
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   input  logic       i_uses_rt,
   output logic       o_match
);

   logic w_nonzero;
   logic w_rs_hit;
   logic w_rt_hit;

   assign w_nonzero = (i_dest != REG_ZERO);
   assign w_rs_hit  = (i_dest == i_rs);
   assign w_rt_hit  = i_uses_rt & (i_dest == i_rt);
   assign o_match   = w_nonzero & (w_rs_hit | w_rt_hit);

endmodule : hazard_stall_unit_reg_match

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Hazard detection and stall control for the 5-stage MIPS pipeline. Detects
// load-use, branch-in-ID operand dependences and multi-cycle data-memory
// accesses, and drives stage enables, bubbles and the IF/ID flush.
// Parameters:
//   MAX_WAIT - consecutive not-ready memory cycles that trip the watchdog
//   CNT_W    - width of the saturating stall-cycle counter
// Ports:
//   clk, reset_n                 - clock (rising edge), async active-low reset
//   ID_rs, ID_rt, ID_UsesRt      - operands of the instruction in ID
//   ID_Branch                    - branch resolved in ID (needs operands)
//   ID_BranchTaken, ID_Jump      - control-flow redirect resolved in ID
//   EX_MemRead, EX_RegWrite,
//   EX_WriteRegister             - EX-stage producer information
//   MEM_MemRead, MEM_WriteRegister - MEM-stage load information
//   MEM_MemAccess, mem_ready     - data-memory handshake
//   PC_Write .. EXMEM_Write      - stage update enables
//   IDEX_Bubble, MEMWB_Bubble    - NOP insertion into ID/EX and MEM/WB
//   IFID_Flush                   - squash the fetched instruction
//   mem_timeout                  - sticky watchdog flag
//   stall_count                  - saturating count of cycles with PC_Write=0
// -----------------------------------------------------------------------------
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = 16
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UsesRt,
   input  logic             ID_Branch,
   input  logic             ID_BranchTaken,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_WriteRegister,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_WriteRegister,
   input  logic             MEM_MemAccess,
   input  logic             mem_ready,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             IDEX_Bubble,
   output logic             MEMWB_Bubble,
   output logic             IFID_Flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   // One spare bit so the counter width is safe for any MAX_WAIT >= 2.
   localparam int              WC_W    = $clog2(MAX_WAIT) + 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WAIT - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0] r_stall_count;

   logic w_ex_ld_match;
   logic w_ex_alu_match;
   logic w_mem_ld_match;
   logic w_load_use;
   logic w_br_haz;
   logic w_hazard;
   logic w_mem_wait;
   logic w_redirect;

   hazard_stall_unit_reg_match u_ex_ld_match (
      .i_dest    (EX_WriteRegister),
      .i_rs      (ID_rs),
      .i_rt      (ID_rt),
      .i_uses_rt (ID_UsesRt),
      .o_match   (w_ex_ld_match)
   );

   hazard_stall_unit_reg_match u_ex_alu_match (
      .i_dest    (EX_WriteRegister),
      .i_rs      (ID_rs),
      .i_rt      (ID_rt),
      .i_uses_rt (ID_UsesRt),
      .o_match   (w_ex_alu_match)
   );

   hazard_stall_unit_reg_match u_mem_ld_match (
      .i_dest    (MEM_WriteRegister),
      .i_rs      (ID_rs),
      .i_rt      (ID_rt),
      .i_uses_rt (ID_UsesRt),
      .o_match   (w_mem_ld_match)
   );

   assign w_load_use = EX_MemRead & w_ex_ld_match;
   // A branch resolved in ID cannot use EX->ID forwarding, and a load in MEM
   // has no data yet, so both force a stall.
   assign w_br_haz   = ID_Branch & ((EX_RegWrite & w_ex_alu_match) |
                                    (MEM_MemRead & w_mem_ld_match));
   assign w_hazard   = w_load_use | w_br_haz;
   assign w_mem_wait = MEM_MemAccess & ~mem_ready;
   assign w_redirect = ID_BranchTaken | ID_Jump;

   always_comb begin
      w_state_nxt  = r_state;
      PC_Write     = 1'b1;
      IFID_Write   = 1'b1;
      IDEX_Write   = 1'b1;
      EXMEM_Write  = 1'b1;
      IDEX_Bubble  = 1'b0;
      MEMWB_Bubble = 1'b0;
      IFID_Flush   = 1'b0;

      case (r_state)
         RUN: begin
            if (w_mem_wait) w_state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_ready)
               w_state_nxt = RUN;
            else if (w_mem_wait && (r_wait_cnt == WC_LAST))
               w_state_nxt = TIMEOUT;
         end
         TIMEOUT: begin
            w_state_nxt = TIMEOUT;
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase

      // Freeze wins over the hazard stall: a bubble inserted while ID/EX is
      // frozen would be lost, so the hazard is simply re-evaluated afterwards.
      if ((r_state == TIMEOUT) || w_mem_wait) begin
         PC_Write     = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_Bubble = 1'b1;
      end else if (w_hazard) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end else if (w_redirect) begin
         IFID_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == TIMEOUT) begin
         r_wait_cnt <= r_wait_cnt;
      end else if (w_mem_wait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_count <= '0;
      end else if (!PC_Write && (r_stall_count != {CNT_W{1'b1}})) begin
         r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign mem_timeout = (r_state == TIMEOUT);
   assign stall_count = r_stall_count;

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

   localparam int TB_MAX_WAIT = 4;
   localparam int TB_CNT_W    = 4;

   // {PC, IFID, IDEX, EXMEM, IDEX_Bubble, MEMWB_Bubble, IFID_Flush, mem_timeout}
   localparam logic [7:0] C_IDLE   = 8'b1111_0000;
   localparam logic [7:0] C_STALL  = 8'b0011_1000;
   localparam logic [7:0] C_FREEZE = 8'b0000_0100;
   localparam logic [7:0] C_FLUSH  = 8'b1111_0010;
   localparam logic [7:0] C_TOUT   = 8'b0000_0101;

   typedef struct {
      logic [7:0]          ctl;
      logic [TB_CNT_W-1:0] cnt;
      string               nm;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [4:0]          ID_rs, ID_rt;
   logic                ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
   logic                EX_MemRead, EX_RegWrite;
   logic [4:0]          EX_WriteRegister;
   logic                MEM_MemRead;
   logic [4:0]          MEM_WriteRegister;
   logic                MEM_MemAccess, mem_ready;
   logic                PC_Write, IFID_Write, IDEX_Write, EXMEM_Write;
   logic                IDEX_Bubble, MEMWB_Bubble, IFID_Flush, mem_timeout;
   logic [TB_CNT_W-1:0] stall_count;

   exp_t                q[$];
   logic [TB_CNT_W-1:0] exp_cnt;
   int                  total = 0;
   int                  bad   = 0;

   hazard_stall_unit #(.MAX_WAIT(TB_MAX_WAIT), .CNT_W(TB_CNT_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .ID_rs             (ID_rs),
      .ID_rt             (ID_rt),
      .ID_UsesRt         (ID_UsesRt),
      .ID_Branch         (ID_Branch),
      .ID_BranchTaken    (ID_BranchTaken),
      .ID_Jump           (ID_Jump),
      .EX_MemRead        (EX_MemRead),
      .EX_RegWrite       (EX_RegWrite),
      .EX_WriteRegister  (EX_WriteRegister),
      .MEM_MemRead       (MEM_MemRead),
      .MEM_WriteRegister (MEM_WriteRegister),
      .MEM_MemAccess     (MEM_MemAccess),
      .mem_ready         (mem_ready),
      .PC_Write          (PC_Write),
      .IFID_Write        (IFID_Write),
      .IDEX_Write        (IDEX_Write),
      .EXMEM_Write       (EXMEM_Write),
      .IDEX_Bubble       (IDEX_Bubble),
      .MEMWB_Bubble      (MEMWB_Bubble),
      .IFID_Flush        (IFID_Flush),
      .mem_timeout       (mem_timeout),
      .stall_count       (stall_count)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are combinational, so every cycle with a pending
   // expectation is checked on the falling edge.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t       e;
         logic [7:0] act;
         e   = q.pop_front();
         act = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write,
                IDEX_Bubble, MEMWB_Bubble, IFID_Flush, mem_timeout};
         total++;
         if (act !== e.ctl) begin
            bad++;
            $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
         end
         total++;
         if (stall_count !== e.cnt) begin
            bad++;
            $display("FAIL %s stall_count: got %0d want %0d", e.nm, stall_count, e.cnt);
         end
      end
   end

   task automatic idle_inputs();
      ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0;
      ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
      EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0;
      MEM_MemRead = 1'b0; MEM_WriteRegister = 5'd0;
      MEM_MemAccess = 1'b0; mem_ready = 1'b0;
   endtask

   // Issue the current input vector for one cycle with its expected controls.
   task automatic cyc(input logic [7:0] ectl, input string nm);
      if (!reset_n) exp_cnt = '0;
      q.push_back('{ctl: ectl, cnt: exp_cnt, nm: nm});
      if (reset_n && !ectl[7] && (exp_cnt != {TB_CNT_W{1'b1}}))
         exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      exp_cnt = '0;
      idle_inputs();
      @(posedge clk);
      #1;
      cyc(C_IDLE, "reset_idle");
      reset_n = 1'b1;
      cyc(C_IDLE, "idle");

      // Load-use on rs: one bubble.
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8;
      cyc(C_STALL, "load_use_rs");
      idle_inputs(); MEM_MemRead = 1'b1; MEM_WriteRegister = 5'd8; ID_rs = 5'd8;
      cyc(C_IDLE, "after_load_use");

      // No hazard through $0 or through an unused rt.
      idle_inputs(); EX_MemRead = 1'b1; EX_WriteRegister = 5'd0;
      cyc(C_IDLE, "reg_zero");
      EX_WriteRegister = 5'd8; ID_rs = 5'd3; ID_rt = 5'd8; ID_UsesRt = 1'b0;
      cyc(C_IDLE, "rt_unused");
      ID_UsesRt = 1'b1;
      cyc(C_STALL, "load_use_rt");

      // Load $9 then beq on $9: two stalls, then a taken-branch flush.
      idle_inputs();
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd9;
      ID_Branch = 1'b1; ID_rs = 5'd9; ID_rt = 5'd2; ID_UsesRt = 1'b1;
      cyc(C_STALL, "br_load_1");
      EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0;
      MEM_MemRead = 1'b1; MEM_WriteRegister = 5'd9;
      cyc(C_STALL, "br_load_2");
      MEM_MemRead = 1'b0; MEM_WriteRegister = 5'd0; ID_BranchTaken = 1'b1;
      cyc(C_FLUSH, "br_taken_flush");

      // Branch after ALU op: one stall.
      idle_inputs();
      EX_RegWrite = 1'b1; EX_WriteRegister = 5'd5; ID_Branch = 1'b1; ID_rs = 5'd5;
      cyc(C_STALL, "br_alu");
      EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0; MEM_WriteRegister = 5'd5;
      cyc(C_IDLE, "br_alu_done");
      idle_inputs(); ID_Jump = 1'b1;
      cyc(C_FLUSH, "jump_flush");

      // MAX_WAIT-1 not-ready cycles: freeze, no timeout, RUN on ready.
      idle_inputs(); MEM_MemAccess = 1'b1;
      for (int i = 0; i < TB_MAX_WAIT - 1; i++) cyc(C_FREEZE, "freeze");
      mem_ready = 1'b1;
      cyc(C_IDLE, "mem_ready");
      idle_inputs();
      cyc(C_IDLE, "post_freeze");

      // Freeze coincident with load-use: no bubble until the freeze ends.
      EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8; MEM_MemAccess = 1'b1;
      cyc(C_FREEZE, "freeze_lu_1");
      cyc(C_FREEZE, "freeze_lu_2");
      mem_ready = 1'b1;
      cyc(C_STALL, "lu_after_freeze");
      idle_inputs();
      cyc(C_IDLE, "lu_one_bubble");

      // MAX_WAIT not-ready cycles: TIMEOUT held even with idle inputs;
      // stall_count saturates.
      MEM_MemAccess = 1'b1;
      for (int i = 0; i < TB_MAX_WAIT; i++) cyc(C_FREEZE, "pre_timeout");
      idle_inputs(); mem_ready = 1'b1;
      cyc(C_TOUT, "timeout_1");
      cyc(C_TOUT, "timeout_sat");
      ID_Jump = 1'b1;
      cyc(C_TOUT, "timeout_held");

      // Asynchronous reset mid-TIMEOUT: outputs return at once.
      idle_inputs();
      reset_n = 1'b0;
      cyc(C_IDLE, "reset_async");
      reset_n = 1'b1;
      cyc(C_IDLE, "post_reset");
      EX_MemRead = 1'b1; EX_WriteRegister = 5'd8; ID_rs = 5'd8;
      cyc(C_STALL, "post_reset_lu");
      idle_inputs();
      cyc(C_IDLE, "post_reset_cnt");

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hazard_stall_unit
